// File: rtl/lc3_control_fsm.sv
// LC-3 control unit: Moore FSM sequencing fetch/decode/execute with MEM_WAIT-cycle SRAM accesses.
// Define LC3_LDI_STI_EN to add the LDI/STI indirect-addressing states.
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE_n,
  output logic       Mem_WE_n
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S00, S22, S12, S04, S21, S20,
    S06, S25, S27, S07, S23, S16, S13, S13W
`ifdef LC3_LDI_STI_EN
    , S10, S11, S24, S29, S26, S30
`endif
  } state_e;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       mio_en, mem_oe_n, mem_we_n;
  } ctrl_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q;

  function automatic logic is_mem(state_e s);
    return (s == S33) || (s == S25) || (s == S16)
`ifdef LC3_LDI_STI_EN
        || (s == S24) || (s == S29)
`endif
        ;
  endfunction

  // Control word for a state; registered from the next state so outputs track state_q exactly.
  function automatic ctrl_t decode(state_e s, logic ir5);
    ctrl_t c;
    c          = '0;
    c.mem_oe_n = 1'b1;
    c.mem_we_n = 1'b1;
    case (s)
      S18: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; end
      S33, S25: begin c.mem_oe_n = 1'b0; c.mio_en = 1'b1; c.ld_mdr = 1'b1; end
      S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      S32: c.ld_ben = 1'b1;
      S01, S05: begin
        c.sr1mux = 1'b1; c.sr2mux = ir5; c.gate_alu = 1'b1;
        c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.aluk   = (s == S05) ? 2'b01 : 2'b00;
      end
      S09: begin
        c.sr1mux = 1'b1; c.aluk = 2'b10; c.gate_alu = 1'b1;
        c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      S22: begin c.addr2mux = 2'b01; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      S12, S20: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b11;
        c.pcmux  = 2'b10; c.ld_pc = 1'b1;
      end
      S04: begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
      S21: begin c.addr2mux = 2'b00; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      S06, S07: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b10;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
      end
      S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      S23: begin c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
      S16: c.mem_we_n = 1'b0;
      S13, S13W: c.ld_led = 1'b1;
`ifdef LC3_LDI_STI_EN
      S10, S11: begin c.addr2mux = 2'b01; c.gate_marmux = 1'b1; c.ld_mar = 1'b1; end
      S24, S29: begin c.mem_oe_n = 1'b0; c.mio_en = 1'b1; c.ld_mdr = 1'b1; end
      S26, S30: begin c.gate_mdr = 1'b1; c.ld_mar = 1'b1; end
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      HALTED: if (Run) state_d = S18;
      S18:    state_d = S33;
      S33:    if (cnt_q == '0) state_d = S35; else cnt_d = cnt_q - 1'b1;
      S35:    state_d = S32;
      S32: begin
        case (Opcode)
          4'b0001: state_d = S01;
          4'b0101: state_d = S05;
          4'b1001: state_d = S09;
          4'b0000: state_d = S00;
          4'b1100: state_d = S12;
          4'b0100: state_d = S04;
          4'b0110: state_d = S06;
          4'b0111: state_d = S07;
          4'b1101: state_d = S13;
`ifdef LC3_LDI_STI_EN
          4'b1010: state_d = S10;
          4'b1011: state_d = S11;
`endif
          default: state_d = S18;
        endcase
      end
      S00:    state_d = BEN ? S22 : S18;
      S04:    state_d = IR_11 ? S21 : S20;
      S06:    state_d = S25;
      S25:    if (cnt_q == '0) state_d = S27; else cnt_d = cnt_q - 1'b1;
      S07:    state_d = S23;
      S23:    state_d = S16;
      S16:    if (cnt_q == '0) state_d = S18; else cnt_d = cnt_q - 1'b1;
      S13:    if (Continue) state_d = S13W;
      // Requiring Continue to drop keeps one long press from releasing two pauses.
      S13W:   if (!Continue) state_d = S18;
`ifdef LC3_LDI_STI_EN
      S10:    state_d = S24;
      S24:    if (cnt_q == '0) state_d = S26; else cnt_d = cnt_q - 1'b1;
      S26:    state_d = S25;
      S11:    state_d = S29;
      S29:    if (cnt_q == '0) state_d = S30; else cnt_d = cnt_q - 1'b1;
      S30:    state_d = S23;
`endif
      S01, S05, S09, S22, S12, S21, S20, S27: state_d = S18;
      default: state_d = HALTED;
    endcase
    if (is_mem(state_d) && (state_d != state_q)) cnt_d = WAIT_LOAD;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= HALTED;
      cnt_q   <= '0;
      ctrl_q  <= decode(HALTED, 1'b0);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode(state_d, IR_5);
    end
  end

  assign LD_MAR     = ctrl_q.ld_mar;
  assign LD_MDR     = ctrl_q.ld_mdr;
  assign LD_IR      = ctrl_q.ld_ir;
  assign LD_BEN     = ctrl_q.ld_ben;
  assign LD_CC      = ctrl_q.ld_cc;
  assign LD_REG     = ctrl_q.ld_reg;
  assign LD_PC      = ctrl_q.ld_pc;
  assign LD_LED     = ctrl_q.ld_led;
  assign GatePC     = ctrl_q.gate_pc;
  assign GateMDR    = ctrl_q.gate_mdr;
  assign GateALU    = ctrl_q.gate_alu;
  assign GateMARMUX = ctrl_q.gate_marmux;
  assign DRMUX      = ctrl_q.drmux;
  assign SR1MUX     = ctrl_q.sr1mux;
  assign SR2MUX     = ctrl_q.sr2mux;
  assign ADDR1MUX   = ctrl_q.addr1mux;
  assign PCMUX      = ctrl_q.pcmux;
  assign ADDR2MUX   = ctrl_q.addr2mux;
  assign ALUK       = ctrl_q.aluk;
  assign MIO_EN     = ctrl_q.mio_en;
  assign Mem_OE_n   = ctrl_q.mem_oe_n;
  assign Mem_WE_n   = ctrl_q.mem_we_n;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: walks instructions through two instances (MEM_WAIT 2 and 3)
// and compares the full control word each cycle against a table of per-state expected outputs.
module tb_lc3_control_fsm;

  logic       Clk = 1'b0;
  logic       Reset, Run, Run3, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic [24:0] o2, o3;
  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {T_HALT, T_18, T_33, T_35, T_32, T_01, T_05, T_09, T_00, T_22, T_12,
                T_04, T_21, T_20, T_06, T_25, T_27, T_07, T_23, T_16, T_13, T_13W} tst_e;

  localparam int B_LD_MAR = 24, B_LD_MDR = 23, B_LD_IR = 22, B_LD_BEN = 21, B_LD_CC = 20;
  localparam int B_LD_REG = 19, B_LD_PC = 18, B_LD_LED = 17, B_GPC = 16, B_GMDR = 15;
  localparam int B_GALU = 14, B_GMARMUX = 13, B_DRMUX = 12, B_SR1MUX = 11, B_SR2MUX = 10;
  localparam int B_ADDR1 = 9, B_MIO = 2, B_OE_N = 1, B_WE_N = 0;

  always #5 Clk = ~Clk;

  lc3_control_fsm #(.MEM_WAIT(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(o2[24]), .LD_MDR(o2[23]), .LD_IR(o2[22]), .LD_BEN(o2[21]), .LD_CC(o2[20]),
    .LD_REG(o2[19]), .LD_PC(o2[18]), .LD_LED(o2[17]), .GatePC(o2[16]), .GateMDR(o2[15]),
    .GateALU(o2[14]), .GateMARMUX(o2[13]), .DRMUX(o2[12]), .SR1MUX(o2[11]), .SR2MUX(o2[10]),
    .ADDR1MUX(o2[9]), .PCMUX(o2[8:7]), .ADDR2MUX(o2[6:5]), .ALUK(o2[4:3]), .MIO_EN(o2[2]),
    .Mem_OE_n(o2[1]), .Mem_WE_n(o2[0])
  );

  lc3_control_fsm #(.MEM_WAIT(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .Run(Run3), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(o3[24]), .LD_MDR(o3[23]), .LD_IR(o3[22]), .LD_BEN(o3[21]), .LD_CC(o3[20]),
    .LD_REG(o3[19]), .LD_PC(o3[18]), .LD_LED(o3[17]), .GatePC(o3[16]), .GateMDR(o3[15]),
    .GateALU(o3[14]), .GateMARMUX(o3[13]), .DRMUX(o3[12]), .SR1MUX(o3[11]), .SR2MUX(o3[10]),
    .ADDR1MUX(o3[9]), .PCMUX(o3[8:7]), .ADDR2MUX(o3[6:5]), .ALUK(o3[4:3]), .MIO_EN(o3[2]),
    .Mem_OE_n(o3[1]), .Mem_WE_n(o3[0])
  );

  // Expected control word per state, written out from the state table.
  function automatic logic [24:0] exp_out(tst_e s, logic ir5);
    logic [24:0] v;
    v = '0;
    v[B_OE_N] = 1'b1;
    v[B_WE_N] = 1'b1;
    case (s)
      T_18:  begin v[B_GPC] = 1; v[B_LD_MAR] = 1; v[B_LD_PC] = 1; end
      T_33, T_25: begin v[B_OE_N] = 0; v[B_MIO] = 1; v[B_LD_MDR] = 1; end
      T_35:  begin v[B_GMDR] = 1; v[B_LD_IR] = 1; end
      T_32:  v[B_LD_BEN] = 1;
      T_01:  begin v[B_SR1MUX] = 1; v[B_SR2MUX] = ir5; v[B_GALU] = 1; v[B_LD_REG] = 1; v[B_LD_CC] = 1; end
      T_05:  begin v[B_SR1MUX] = 1; v[B_SR2MUX] = ir5; v[4:3] = 2'b01; v[B_GALU] = 1;
                   v[B_LD_REG] = 1; v[B_LD_CC] = 1; end
      T_09:  begin v[B_SR1MUX] = 1; v[4:3] = 2'b10; v[B_GALU] = 1; v[B_LD_REG] = 1; v[B_LD_CC] = 1; end
      T_22:  begin v[6:5] = 2'b01; v[8:7] = 2'b10; v[B_LD_PC] = 1; end
      T_12, T_20: begin v[B_SR1MUX] = 1; v[B_ADDR1] = 1; v[6:5] = 2'b11; v[8:7] = 2'b10; v[B_LD_PC] = 1; end
      T_04:  begin v[B_GPC] = 1; v[B_DRMUX] = 1; v[B_LD_REG] = 1; end
      T_21:  begin v[8:7] = 2'b10; v[B_LD_PC] = 1; end
      T_06, T_07: begin v[B_SR1MUX] = 1; v[B_ADDR1] = 1; v[6:5] = 2'b10; v[B_GMARMUX] = 1; v[B_LD_MAR] = 1; end
      T_27:  begin v[B_GMDR] = 1; v[B_LD_REG] = 1; v[B_LD_CC] = 1; end
      T_23:  begin v[4:3] = 2'b11; v[B_GALU] = 1; v[B_LD_MDR] = 1; end
      T_16:  v[B_WE_N] = 0;
      T_13, T_13W: v[B_LD_LED] = 1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic set_ir(input logic [15:0] ir);
    Opcode = ir[15:12];
    IR_11  = ir[11];
    IR_5   = ir[5];
  endtask

  task automatic test_reset();
    logic [24:0] want;
    Reset = 1'b0; Run = 1'b0; Run3 = 1'b0; Continue = 1'b0; BEN = 1'b0;
    set_ir(16'h0000);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      n_checks++;
      want = exp_out(T_HALT, IR_5);
      if (o2 !== want) begin n_fail++; $display("FAIL reset_halted[%0d]: got %b want %b", i, o2, want); end
    end
    n_checks++;
    if (o3 !== exp_out(T_HALT, IR_5)) begin n_fail++; $display("FAIL reset_halted_dut3: got %b", o3); end
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    n_checks++;
    if (o2 !== exp_out(T_18, IR_5)) begin n_fail++; $display("FAIL reset_first_s18: got %b want %b", o2, exp_out(T_18, IR_5)); end
    @(negedge Clk);
    n_checks++;
    if (o2 !== exp_out(T_33, IR_5)) begin n_fail++; $display("FAIL reset_s33: got %b want %b", o2, exp_out(T_33, IR_5)); end
    #3 Reset = 1'b0;
    #1;
    n_checks++;
    if (o2 !== exp_out(T_HALT, IR_5)) begin n_fail++; $display("FAIL reset_mid_s33: got %b want %b", o2, exp_out(T_HALT, IR_5)); end
    n_checks++;
    if (o2[B_OE_N] !== 1'b1) begin n_fail++; $display("FAIL reset_mid_s33_oe: got %b want 1", o2[B_OE_N]); end
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      n_checks++;
      if (o2 !== exp_out(T_HALT, IR_5)) begin n_fail++; $display("FAIL post_reset_halted[%0d]: got %b", i, o2); end
    end
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    n_checks++;
    if (o2 !== exp_out(T_18, IR_5)) begin n_fail++; $display("FAIL run_to_s18: got %b want %b", o2, exp_out(T_18, IR_5)); end
  endtask

  task automatic test_alu();
    logic [15:0] irs [3] = '{16'h1ABD, 16'h5042, 16'h927F};
    tst_e        ex  [3] = '{T_01, T_05, T_09};
    tst_e        seq [$];
    logic [24:0] want;
    for (int k = 0; k < 3; k++) begin
      set_ir(irs[k]);
      seq = '{T_33, T_33, T_35, T_32, ex[k], T_18};
      foreach (seq[i]) begin
        @(negedge Clk);
        n_checks++;
        want = exp_out(seq[i], IR_5);
        if (o2 !== want) begin
          n_fail++;
          $display("FAIL alu %h step %0d %s: got %b want %b", irs[k], i, seq[i].name(), o2, want);
        end
      end
    end
  endtask

  task automatic test_branch();
    tst_e        seq [$];
    logic [24:0] want;
    set_ir(16'h0A05);
    for (int b = 0; b < 2; b++) begin
      BEN = b[0];
      if (b == 0) seq = '{T_33, T_33, T_35, T_32, T_00, T_18};
      else        seq = '{T_33, T_33, T_35, T_32, T_00, T_22, T_18};
      foreach (seq[i]) begin
        @(negedge Clk);
        n_checks++;
        want = exp_out(seq[i], IR_5);
        if (o2 !== want) begin
          n_fail++;
          $display("FAIL br ben=%0d step %0d %s: got %b want %b", b, i, seq[i].name(), o2, want);
        end
      end
    end
    BEN = 1'b0;
  endtask

  task automatic test_jmp_jsr();
    logic [15:0] irs [3] = '{16'hC080, 16'h4805, 16'h4080};
    tst_e        seq [$];
    logic [24:0] want;
    for (int k = 0; k < 3; k++) begin
      set_ir(irs[k]);
      case (k)
        0:       seq = '{T_33, T_33, T_35, T_32, T_12, T_18};
        1:       seq = '{T_33, T_33, T_35, T_32, T_04, T_21, T_18};
        default: seq = '{T_33, T_33, T_35, T_32, T_04, T_20, T_18};
      endcase
      foreach (seq[i]) begin
        @(negedge Clk);
        n_checks++;
        want = exp_out(seq[i], IR_5);
        if (o2 !== want) begin
          n_fail++;
          $display("FAIL jmp_jsr %h step %0d %s: got %b want %b", irs[k], i, seq[i].name(), o2, want);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [15:0] irs [2] = '{16'h6A42, 16'h7A42};
    tst_e        seq [$];
    logic [24:0] want;
    for (int k = 0; k < 2; k++) begin
      set_ir(irs[k]);
      if (k == 0) seq = '{T_33, T_33, T_35, T_32, T_06, T_25, T_25, T_27, T_18};
      else        seq = '{T_33, T_33, T_35, T_32, T_07, T_23, T_16, T_16, T_18};
      foreach (seq[i]) begin
        @(negedge Clk);
        n_checks++;
        want = exp_out(seq[i], IR_5);
        if (o2 !== want) begin
          n_fail++;
          $display("FAIL mem %h step %0d %s: got %b want %b", irs[k], i, seq[i].name(), o2, want);
        end
      end
    end
  endtask

  task automatic test_pause();
    tst_e        seq [$];
    logic [24:0] want;
    set_ir(16'hD0FF);
    for (int k = 0; k < 2; k++) begin
      Continue = (k == 0);
      if (k == 0) seq = '{T_33, T_33, T_35, T_32, T_13, T_13W, T_13W, T_13W};
      else        seq = '{T_33, T_33, T_35, T_32, T_13, T_13, T_13};
      foreach (seq[i]) begin
        @(negedge Clk);
        n_checks++;
        want = exp_out(seq[i], IR_5);
        if (o2 !== want) begin
          n_fail++;
          $display("FAIL pause case%0d step %0d %s: got %b want %b", k, i, seq[i].name(), o2, want);
        end
      end
      if (k == 1) begin
        Continue = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (o2 !== exp_out(T_13W, IR_5)) begin n_fail++; $display("FAIL pause_enter_s13w: got %b", o2); end
      end
      Continue = 1'b0;
      @(negedge Clk);
      n_checks++;
      if (o2 !== exp_out(T_18, IR_5)) begin n_fail++; $display("FAIL pause_release case%0d: got %b want %b", k, o2, exp_out(T_18, IR_5)); end
    end
  endtask

  task automatic test_nop();
    logic [15:0] irs [3] = '{16'h2000, 16'hA000, 16'hB000};
    tst_e        seq [$];
    logic [24:0] want;
    Run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ir(irs[k]);
      seq = '{T_33, T_33, T_35, T_32, T_18};
      foreach (seq[i]) begin
        @(negedge Clk);
        n_checks++;
        want = exp_out(seq[i], IR_5);
        if (o2 !== want) begin
          n_fail++;
          $display("FAIL nop %h step %0d %s: got %b want %b", irs[k], i, seq[i].name(), o2, want);
        end
      end
    end
    Run = 1'b0;
  endtask

  task automatic test_str_wait3();
    tst_e        seq [$];
    logic [24:0] want;
    int          we_low = 0;
    set_ir(16'h7A42);
    Run3 = 1'b1;
    @(negedge Clk);
    Run3 = 1'b0;
    n_checks++;
    if (o3 !== exp_out(T_18, IR_5)) begin n_fail++; $display("FAIL str3_s18: got %b want %b", o3, exp_out(T_18, IR_5)); end
    seq = '{T_33, T_33, T_33, T_35, T_32, T_07, T_23, T_16, T_16, T_16, T_18};
    foreach (seq[i]) begin
      @(negedge Clk);
      if (o3[B_WE_N] === 1'b0) we_low++;
      n_checks++;
      want = exp_out(seq[i], IR_5);
      if (o3 !== want) begin
        n_fail++;
        $display("FAIL str3 step %0d %s: got %b want %b", i, seq[i].name(), o3, want);
      end
    end
    n_checks++;
    if (we_low !== 3) begin n_fail++; $display("FAIL str3_we_cycles: got %0d want 3", we_low); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jmp_jsr();
    test_mem();
    test_pause();
    test_nop();
    test_str_wait3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
